// File: rtl/pool_pkg.sv
// Shared pooling definitions: mode encodings, window FSM states and the
// power-of-two decoder also used by the conv config decoder.
package pool_pkg;

  localparam logic POOL_MAX = 1'b0;
  localparam logic POOL_AVG = 1'b1;
  localparam int   SHIFT_W  = 4;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_ACC  = 1'b1
  } win_state_t;

  typedef struct packed {
    logic               legal;
    logic [SHIFT_W-1:0] shift;
  } pow2_t;

  // legal=1 only when p is an exact power of two; shift is then log2(p)
  function automatic pow2_t log2_pow2(input logic [15:0] p);
    pow2_t r;
    r = '0;
    for (int i = 0; i < 16; i++) begin
      if (p == (16'd1 << i)) begin
        r.legal = 1'b1;
        r.shift = i[SHIFT_W-1:0];
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/pool_lane.sv
// One pooling lane: running signed max or sum over a window, then the
// average shift and optional ReLU on the closing beat.
module pool_lane
  import pool_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int SUM_W  = 11
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic signed [DATA_W-1:0] i_data,
  input  logic                     i_accept,
  input  logic                     i_first,
  input  logic                     i_close,
  input  logic                     i_mode,
  input  logic                     i_relu,
  input  logic [SHIFT_W-1:0]       i_shift,
  output logic signed [DATA_W-1:0] o_res
);

  logic signed [SUM_W-1:0] r_acc;
  logic signed [SUM_W-1:0] w_din;
  logic signed [SUM_W-1:0] w_next;
  logic signed [SUM_W-1:0] w_scaled;

  // The sum never exceeds DATA_W bits after the shift, so truncation is exact
  function automatic logic signed [DATA_W-1:0] relu_trunc(
    input logic signed [SUM_W-1:0] v,
    input logic                    relu
  );
    logic signed [DATA_W-1:0] t;
    t = v[DATA_W-1:0];
    if (relu && t[DATA_W-1]) t = '0;
    return t;
  endfunction

  assign w_din = {{(SUM_W-DATA_W){i_data[DATA_W-1]}}, i_data};

  // The first beat seeds the accumulator so max mode has no artificial floor
  always_comb begin
    w_next = w_din;
    if (!i_first) begin
      if (i_mode == POOL_AVG) w_next = r_acc + w_din;
      else                    w_next = (w_din > r_acc) ? w_din : r_acc;
    end
  end

  assign w_scaled = (i_mode == POOL_AVG) ? (w_next >>> i_shift) : w_next;
  assign o_res    = relu_trunc(w_scaled, i_relu);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        r_acc <= '0;
    else if (i_accept) r_acc <= i_close ? '0 : w_next;
  end

endmodule

// File: rtl/pool_stream.sv
// Streaming ReLU + max/average pooling over runtime-sized windows of beats,
// one registered CH-lane result per window over valid/ready.
module pool_stream
  import pool_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int CH     = 4,
  parameter int MAX_P  = 8,
  parameter int PW     = $clog2(MAX_P + 1)
) (
  input  logic                 clk_cal,
  input  logic                 rst_cal_n,
  input  logic [PW-1:0]        cfg_p,
  input  logic                 cfg_mode,
  input  logic                 cfg_relu,
  input  logic [CH*DATA_W-1:0] in_data,
  input  logic                 in_valid,
  input  logic                 in_last,
  output logic                 in_ready,
  output logic [CH*DATA_W-1:0] out_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 cfg_err
);

  localparam int SUM_W = DATA_W + $clog2(MAX_P);

  win_state_t           r_state;
  win_state_t           w_state_nxt;
  logic [PW-1:0]        r_cnt;
  logic [PW-1:0]        r_p;
  logic                 r_mode;
  logic                 r_relu;
  logic [SHIFT_W-1:0]   r_shift;
  logic                 r_cfg_err;
  logic                 r_out_valid;
  logic [CH*DATA_W-1:0] r_out_data;

  pow2_t                w_pw;
  logic                 w_cfg_illegal;
  logic [PW-1:0]        w_p_first;
  logic [SHIFT_W-1:0]   w_shift_first;
  logic                 w_accept;
  logic                 w_first;
  logic                 w_close;
  logic [PW-1:0]        w_p;
  logic                 w_mode;
  logic                 w_relu;
  logic [SHIFT_W-1:0]   w_shift;
  logic [CH*DATA_W-1:0] w_res;

  assign w_pw          = log2_pow2(16'(cfg_p));
  assign w_cfg_illegal = (cfg_p == '0) || (cfg_p > PW'(MAX_P)) ||
                         ((cfg_mode == POOL_AVG) && !w_pw.legal);
  // An illegal window degrades to p=1 but keeps the requested mode
  assign w_p_first     = w_cfg_illegal ? PW'(1) : cfg_p;
  assign w_shift_first = w_cfg_illegal ? '0 : w_pw.shift;

  assign in_ready = !(r_out_valid && !out_ready);
  assign w_accept = in_valid && in_ready;
  assign w_first  = w_accept && (r_state == ST_IDLE);

  // Config used by the current beat: live on the opening beat, latched after
  assign w_p     = w_first ? w_p_first     : r_p;
  assign w_mode  = w_first ? cfg_mode      : r_mode;
  assign w_relu  = w_first ? cfg_relu      : r_relu;
  assign w_shift = w_first ? w_shift_first : r_shift;
  assign w_close = w_accept && ((r_cnt == (w_p - PW'(1))) || in_last);

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (w_accept && !w_close) w_state_nxt = ST_ACC;
      ST_ACC:  if (w_close)              w_state_nxt = ST_IDLE;
      default:                           w_state_nxt = ST_IDLE;
    endcase
  end

  for (genvar k = 0; k < CH; k++) begin : g_lane
    pool_lane #(
      .DATA_W(DATA_W),
      .SUM_W (SUM_W)
    ) u_lane (
      .clk     (clk_cal),
      .rst_n   (rst_cal_n),
      .i_data  (in_data[k*DATA_W +: DATA_W]),
      .i_accept(w_accept),
      .i_first (w_first),
      .i_close (w_close),
      .i_mode  (w_mode),
      .i_relu  (w_relu),
      .i_shift (w_shift),
      .o_res   (w_res[k*DATA_W +: DATA_W])
    );
  end

  always_ff @(posedge clk_cal or negedge rst_cal_n) begin
    if (!rst_cal_n) begin
      r_state     <= ST_IDLE;
      r_cnt       <= '0;
      r_p         <= PW'(1);
      r_mode      <= POOL_MAX;
      r_relu      <= 1'b0;
      r_shift     <= '0;
      r_cfg_err   <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_cfg_err <= w_first && w_cfg_illegal;
      if (w_close)       r_cnt <= '0;
      else if (w_accept) r_cnt <= r_cnt + PW'(1);
      if (w_first) begin
        r_p     <= w_p_first;
        r_mode  <= cfg_mode;
        r_relu  <= cfg_relu;
        r_shift <= w_shift_first;
      end
      // A close is only accepted when the output slot is free or draining now
      if (w_close) begin
        r_out_valid <= 1'b1;
        r_out_data  <= w_res;
      end else if (out_ready) begin
        r_out_valid <= 1'b0;
      end
    end
  end

  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign cfg_err   = r_cfg_err;

endmodule

// File: tb/tb_pool_stream.sv
// Scoreboard bench for pool_stream: window-level reference model feeds an
// expected-result queue that a separate output monitor drains.
module tb_pool_stream;

  localparam int DATA_W = 8;
  localparam int CH     = 4;
  localparam int MAX_P  = 8;
  localparam int PW     = 4;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic [PW-1:0]        cfg_p = '0;
  logic                 cfg_mode = 1'b0;
  logic                 cfg_relu = 1'b0;
  logic [CH*DATA_W-1:0] in_data = '0;
  logic                 in_valid = 1'b0;
  logic                 in_last = 1'b0;
  logic                 in_ready;
  logic [CH*DATA_W-1:0] out_data;
  logic                 out_valid;
  logic                 out_ready = 1'b1;
  logic                 cfg_err;

  pool_stream #(.DATA_W(DATA_W), .CH(CH), .MAX_P(MAX_P)) dut (
    .clk_cal  (clk),
    .rst_cal_n(rst_n),
    .cfg_p    (cfg_p),
    .cfg_mode (cfg_mode),
    .cfg_relu (cfg_relu),
    .in_data  (in_data),
    .in_valid (in_valid),
    .in_last  (in_last),
    .in_ready (in_ready),
    .out_data (out_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .cfg_err  (cfg_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // reference window state
  logic [CH*DATA_W-1:0] exp_q[$];
  int  m_acc[CH];
  int  m_n = 0;
  int  m_p = 1;
  int  m_shift = 0;
  bit  m_mode = 0;
  bit  m_relu = 0;
  int  err_exp = 0;
  int  err_obs = 0;
  bit  close_pend = 0;
  bit  rst_seen = 0;
  int  ready_mode = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] pack4(input int a, input int b, input int c, input int d);
    return {8'(d), 8'(c), 8'(b), 8'(a)};
  endfunction

  task automatic model_beat(input logic [31:0] d, input bit last, input int p,
                            input bit mode, input bit relu);
    int v;
    int r;
    bit illegal;
    logic [31:0] e;
    if (m_n == 0) begin
      illegal = (p == 0) || (p > MAX_P) ||
                (mode && !(p == 1 || p == 2 || p == 4 || p == 8));
      m_p     = illegal ? 1 : p;
      m_shift = illegal ? 0 : (p == 2 ? 1 : p == 4 ? 2 : p == 8 ? 3 : 0);
      m_mode  = mode;
      m_relu  = relu;
      if (illegal) err_exp++;
    end
    for (int k = 0; k < CH; k++) begin
      v = $signed(d[k*8 +: 8]);
      if (m_n == 0)    m_acc[k] = v;
      else if (m_mode) m_acc[k] = m_acc[k] + v;
      else if (v > m_acc[k]) m_acc[k] = v;
    end
    m_n++;
    if (m_n == m_p || last) begin
      for (int k = 0; k < CH; k++) begin
        r = m_mode ? (m_acc[k] >>> m_shift) : m_acc[k];
        if (m_relu && r < 0) r = 0;
        e[k*8 +: 8] = r[7:0];
      end
      exp_q.push_back(e);
      m_n = 0;
      close_pend = 1;
    end
  endtask

  // Tasks below are entered 1 time unit after a rising edge and return likewise
  task automatic beat(input logic [31:0] d, input bit last, input int p,
                      input bit mode, input bit relu);
    int t;
    t = 0;
    in_valid = 1'b1;
    in_data  = d;
    in_last  = last;
    cfg_p    = p[3:0];
    cfg_mode = mode;
    cfg_relu = relu;
    #1;
    while (!in_ready && t < 200) begin
      @(posedge clk); #2;
      t++;
    end
    if (!in_ready) chk("accept_timeout", 0, 1);
    else           model_beat(d, last, p, mode, relu);
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (exp_q.size() > 0 && t < 500) begin
      @(posedge clk); #1;
      t++;
    end
    chk("drain_left", exp_q.size(), 0);
    idle(2);
    chk("cfg_err_count", err_obs, err_exp);
  endtask

  task automatic do_reset();
    rst_n    = 1'b0;
    rst_seen = 1'b1;
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_cfg_err", cfg_err, 0);
    chk("rst_in_ready", in_ready, 1);
    exp_q.delete();
    m_n        = 0;
    close_pend = 0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  always begin
    @(posedge clk); #1;
    case (ready_mode)
      0:       out_ready = 1'b1;
      1:       out_ready = ($urandom_range(0, 3) != 0);
      default: out_ready = 1'b0;
    endcase
  end

  always begin
    @(posedge clk); #1;
    if (close_pend) begin
      chk("latency_out_valid", out_valid, 1);
      close_pend = 0;
    end
  end

  logic                 hold = 0;
  logic [CH*DATA_W-1:0] hold_data = '0;
  always begin
    @(negedge clk);
    if (!rst_n || rst_seen) begin
      hold     = 0;
      rst_seen = 0;
    end else begin
      if (hold) begin
        chk("hold_valid", out_valid, 1);
        chk("hold_data", out_data, hold_data);
      end
      chk("in_ready_rule", in_ready, !(out_valid && !out_ready));
      if (cfg_err) err_obs++;
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) chk("unexpected_out", 1, 0);
        else                   chk("out_data", out_data, exp_q.pop_front());
      end
      hold      = out_valid && !out_ready;
      hold_data = out_data;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    #1;
    chk("init_out_valid", out_valid, 0);
    chk("init_out_data", out_data, 0);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    chk("post_rst_in_ready", in_ready, 1);

    // max, p=4; lane 3 all negative must give -2
    beat(pack4(-3, 5, 2, -5), 0, 4, 0, 0);
    beat(pack4(7, -1, 0, -2), 0, 4, 0, 0);
    beat(pack4(1, 4, -6, -9), 0, 4, 0, 0);
    beat(pack4(-4, 3, 6, -7), 0, 4, 0, 0);
    beat(pack4(-128, 127, -1, 0), 0, 4, 0, 0);
    beat(pack4(-100, -128, -2, 1), 0, 4, 0, 0);
    beat(pack4(-127, 0, -3, -1), 0, 4, 0, 0);
    beat(pack4(-128, 5, -4, 2), 0, 4, 0, 0);
    drain();

    // avg, p=4, without and with ReLU
    beat(pack4(10, -1, 127, -128), 0, 4, 1, 0);
    beat(pack4(11, -1, 127, -128), 0, 4, 1, 0);
    beat(pack4(12, -1, 127, -128), 0, 4, 1, 0);
    beat(pack4(-2, -2, 127, -128), 0, 4, 1, 0);
    beat(pack4(10, -1, 3, -9), 0, 4, 1, 1);
    beat(pack4(11, -1, 3, 2), 0, 4, 1, 1);
    beat(pack4(12, -1, 3, 0), 0, 4, 1, 1);
    beat(pack4(-2, -2, 3, 1), 0, 4, 1, 1);
    drain();

    // partial windows closed by in_last, then a clean full window
    beat(pack4(9, -7, 1, 0), 0, 4, 0, 0);
    beat(pack4(3, -9, 2, 0), 1, 4, 0, 0);
    beat(pack4(9, -7, 1, 0), 0, 4, 1, 0);
    beat(pack4(3, -9, 2, 0), 1, 4, 1, 0);
    for (int i = 0; i < 4; i++) beat(pack4(i, -i, 2 * i, 5), 0, 4, 1, 0);
    drain();

    // p=1 under 6 cycles of backpressure
    ready_mode = 2;
    fork
      begin repeat (6) @(posedge clk); ready_mode = 0; end
    join_none
    for (int i = 0; i < 8; i++) beat(pack4(i * 13 - 50, -i, i, 100 - i), 0, 1, 0, 1);
    drain();

    // illegal configs and ignored mid-window change
    beat(pack4(7, -7, 3, -3), 0, 0, 1, 0);
    beat(pack4(5, 6, -5, -6), 0, 3, 1, 0);
    beat(pack4(1, 2, 3, 4), 0, 12, 0, 0);
    beat(pack4(20, 20, 20, 20), 0, 4, 1, 0);
    beat(pack4(20, 20, 20, 20), 0, 2, 1, 0);
    beat(pack4(20, 20, 20, 20), 0, 2, 1, 0);
    beat(pack4(-60, 4, 0, 20), 0, 2, 1, 0);
    drain();

    // reset with a held result, then reset mid-window
    ready_mode = 2;
    for (int i = 0; i < 4; i++) beat(pack4(i, i, i, i), 0, 4, 0, 0);
    idle(2);
    do_reset();
    ready_mode = 0;
    idle(1);
    beat(pack4(50, 50, 50, 50), 0, 4, 0, 0);
    beat(pack4(60, 60, 60, 60), 0, 4, 0, 0);
    idle(1);
    do_reset();
    idle(1);
    for (int i = 0; i < 4; i++) beat(pack4(-10 - i, i, -i, 3), 0, 4, 0, 0);
    drain();

    // randomized traffic with random backpressure
    ready_mode = 1;
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 5) == 0) idle($urandom_range(1, 2));
      beat($urandom(), ($urandom_range(0, 7) == 0), $urandom_range(0, 10),
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end
    ready_mode = 0;
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
